// File: rtl/mem_load_queue_pkg.sv
// Shared encodings and entry types for the memory-stage result queue.
package mem_load_queue_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Control half of a queue entry; the data-width fields live in per-field arrays in the top.
  typedef struct packed {
    logic       req;
    logic       done;
    logic [1:0] size;
    logic       sgn;
  } ent_meta_t;

  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = ptr_w(4);

endpackage

// File: rtl/mem_load_queue_load_extend.sv
// Load lane select plus sign/zero extension to the full bus width.
module load_extend
  import mem_load_queue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           rdata,
  input  logic [$clog2(DATA_W/8)-1:0] addr_low,
  input  logic [1:0]                  size,
  input  logic                        sgn,
  output logic [DATA_W-1:0]           data
);

  logic [DATA_W-1:0] lane, up;
  logic [6:0]        sh;

  // Move the field to the top, then shift back down arithmetically or logically.
  always_comb begin
    lane = rdata >> {addr_low, 3'b000};
    case (size)
      SZ_B:    sh = 7'(DATA_W - 8);
      SZ_H:    sh = 7'(DATA_W - 16);
      SZ_W:    sh = 7'(DATA_W - 32);
      default: sh = 7'd0;
    endcase
    up   = lane << sh;
    data = sgn ? $unsigned($signed(up) >>> sh) : (up >> sh);
  end

endmodule

// File: rtl/mem_load_queue.sv
// MEM-stage result queue: tracks in-flight memory ops, matches in-order responses, drains to WB.
module mem_load_queue
  import mem_load_queue_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int RADDR_W = 5,
  parameter int PC_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_allowin,
  input  logic                        in_req,
  input  logic [1:0]                  in_size,
  input  logic                        in_signed,
  input  logic [$clog2(DATA_W/8)-1:0] in_addr_low,
  input  logic                        in_regs_we,
  input  logic [RADDR_W-1:0]          in_regs_waddr,
  input  logic [DATA_W-1:0]           in_regs_wdata,
  input  logic [PC_W-1:0]             in_pc,
  input  logic                        data_sram_data_ok,
  input  logic [DATA_W-1:0]           data_sram_rdata,
  input  logic                        excep_flush,
  output logic                        out_valid,
  input  logic                        out_allowin,
  output logic                        out_regs_we,
  output logic [RADDR_W-1:0]          out_regs_waddr,
  output logic [DATA_W-1:0]           out_regs_wdata,
  output logic [PC_W-1:0]             out_pc,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic                        rsp_err
);

  localparam int AW = $clog2(DATA_W/8);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = IW + 2;

  ent_meta_t          meta    [DEPTH];
  logic [AW-1:0]      al_q    [DEPTH];
  logic               we_q    [DEPTH];
  logic [RADDR_W-1:0] waddr_q [DEPTH];
  logic [DATA_W-1:0]  wdata_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] discard_cnt;
  logic [IW-1:0] hidx, tidx, sel, idx;
  logic [IW:0]   outst;
  logic [CW:0]   disc_sum;
  logic [CW-1:0] disc_nxt;
  logic          found, empty, full, consume, match, head_hit, dec, enq, deq;
  ent_meta_t     sel_meta;
  logic [DATA_W-1:0] ext_data;

  assign hidx      = head[IW-1:0];
  assign tidx      = tail[IW-1:0];
  assign occupancy = tail - head;
  assign empty     = (head == tail);
  assign full      = (hidx == tidx) && (head[IW] != tail[IW]);

  // Oldest live entry still waiting for data; responses arrive in issue order.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    outst = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = hidx + IW'(k);
      if ((IW+1)'(k) < occupancy && meta[idx].req && !meta[idx].done) begin
        outst = outst + 1'b1;
        if (!found) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  assign sel_meta = meta[sel];

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata    (data_sram_rdata),
    .addr_low (al_q[sel]),
    .size     (sel_meta.size),
    .sgn      (sel_meta.sgn),
    .data     (ext_data)
  );

  assign consume  = data_sram_data_ok && (discard_cnt == '0);
  assign match    = consume && found;
  assign head_hit = match && (sel == hidx);

  assign out_valid      = ~rst & ~excep_flush & ~empty & (meta[hidx].done | head_hit);
  assign out_regs_we    = we_q[hidx];
  assign out_regs_waddr = waddr_q[hidx];
  assign out_regs_wdata = head_hit ? ext_data : wdata_q[hidx];
  assign out_pc         = pc_q[hidx];

  assign in_allowin = ~rst & ~excep_flush & (~full | (out_valid & out_allowin));
  assign enq        = in_valid & in_allowin;
  assign deq        = out_valid & out_allowin;

  // A response either retires a discard slot or lands on an outstanding entry, never underflows.
  assign dec      = data_sram_data_ok && ((discard_cnt != '0) || found);
  assign disc_sum = {1'b0, discard_cnt} + (CW+1)'(outst) - (CW+1)'(dec);
  assign disc_nxt = disc_sum[CW] ? '1 : disc_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      discard_cnt <= '0;
      rsp_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) meta[i] <= '0;
    end else begin
      if (data_sram_data_ok && (discard_cnt == '0) && !found) rsp_err <= 1'b1;
      if (match) begin
        meta[sel].done <= 1'b1;
        wdata_q[sel]   <= ext_data;
      end
      if (excep_flush) begin
        head        <= tail;
        discard_cnt <= disc_nxt;
      end else begin
        if (data_sram_data_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
        if (deq) head <= head + 1'b1;
        // When full, tail aliases the departing head slot; this write must win over the response write.
        if (enq) begin
          tail          <= tail + 1'b1;
          meta[tidx]    <= '{req: in_req, done: ~in_req, size: in_size, sgn: in_signed};
          al_q[tidx]    <= in_addr_low;
          we_q[tidx]    <= in_regs_we;
          waddr_q[tidx] <= in_regs_waddr;
          wdata_q[tidx] <= in_regs_wdata;
          pc_q[tidx]    <= in_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_load_queue.sv
// Bench for mem_load_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_load_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int DMAX  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 0, in_req = 0, in_signed = 0, in_regs_we = 0;
  logic [1:0]  in_size = 0;
  logic [2:0]  in_addr_low = 0;
  logic [4:0]  in_regs_waddr = 0;
  logic [63:0] in_regs_wdata = 0, rdata = 0;
  logic [31:0] in_pc = 0;
  logic        data_ok = 0, flush = 0, out_allowin = 0;

  logic        in_allowin, out_valid, out_regs_we, rsp_err;
  logic [4:0]  out_regs_waddr;
  logic [63:0] out_regs_wdata;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  logic        allow32, valid32, we32, err32;
  logic [4:0]  wa32;
  logic [31:0] wdata32, pc32;
  logic [2:0]  occ32;

  always #5 clk = ~clk;

  mem_load_queue #(.DATA_W(64), .DEPTH(DEPTH), .RADDR_W(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_allowin(in_allowin), .in_req(in_req),
    .in_size(in_size), .in_signed(in_signed), .in_addr_low(in_addr_low), .in_regs_we(in_regs_we),
    .in_regs_waddr(in_regs_waddr), .in_regs_wdata(in_regs_wdata), .in_pc(in_pc),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .excep_flush(flush),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_regs_we(out_regs_we),
    .out_regs_waddr(out_regs_waddr), .out_regs_wdata(out_regs_wdata), .out_pc(out_pc),
    .occupancy(occupancy), .rsp_err(rsp_err));

  mem_load_queue #(.DATA_W(32), .DEPTH(DEPTH), .RADDR_W(5), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_allowin(allow32), .in_req(in_req),
    .in_size(in_size), .in_signed(in_signed), .in_addr_low(in_addr_low[1:0]), .in_regs_we(in_regs_we),
    .in_regs_waddr(in_regs_waddr), .in_regs_wdata(in_regs_wdata[31:0]), .in_pc(in_pc),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata[31:0]), .excep_flush(flush),
    .out_valid(valid32), .out_allowin(out_allowin), .out_regs_we(we32),
    .out_regs_waddr(wa32), .out_regs_wdata(wdata32), .out_pc(pc32),
    .occupancy(occ32), .rsp_err(err32));

  typedef struct {
    bit        req, done, sgn, we;
    bit [1:0]  size;
    bit [2:0]  al;
    bit [4:0]  wa;
    bit [63:0] wd;
    bit [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   disc = 0;
  bit   err  = 0;
  int   total = 0, bad = 0;

  bit          e_valid, e_allow, e_we;
  logic [63:0] e_wdata;
  logic [4:0]  e_wa;
  logic [31:0] e_pc;
  int          e_occ;

  function automatic logic [63:0] ext(logic [63:0] rd, logic [1:0] sz, bit sg, logic [2:0] al);
    logic [63:0] lane, mask, v;
    int n;
    lane = rd >> (al * 8);
    n = 8 << sz;
    if (n == 64) return lane;
    mask = (64'd1 << n) - 64'd1;
    v = lane & mask;
    if (sg && lane[n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic int n_out();
    int c = 0;
    foreach (q[i]) if (q[i].req && !q[i].done) c++;
    return c;
  endfunction

  task automatic predict();
    bit hit;
    e_occ = q.size();
    hit = data_ok && disc == 0 && q.size() > 0 && q[0].req && !q[0].done;
    e_valid = !rst && !flush && q.size() > 0 && (q[0].done || hit);
    if (q.size() > 0) begin
      e_wdata = hit ? ext(rdata, q[0].size, q[0].sgn, q[0].al) : q[0].wd;
      e_we = q[0].we; e_wa = q[0].wa; e_pc = q[0].pc;
    end
    e_allow = !rst && !flush && (q.size() < DEPTH || (e_valid && out_allowin));
  endtask

  task automatic tick();
    ent_t t;
    bit hit_any;
    predict();
    @(posedge clk);
    if (rst) begin
      q.delete(); disc = 0; err = 0;
    end else begin
      if (data_ok) begin
        if (disc > 0) disc--;
        else begin
          hit_any = 0;
          foreach (q[i]) if (!hit_any && q[i].req && !q[i].done) begin
            t = q[i]; t.done = 1; t.wd = ext(rdata, t.size, t.sgn, t.al); q[i] = t;
            hit_any = 1;
          end
          if (!hit_any) err = 1;
        end
      end
      if (flush) begin
        disc = disc + n_out();
        if (disc > DMAX) disc = DMAX;
        q.delete();
      end else begin
        if (e_valid && out_allowin) void'(q.pop_front());
        if (in_valid && e_allow) begin
          t.req = in_req; t.done = !in_req; t.sgn = in_signed; t.we = in_regs_we;
          t.size = in_size; t.al = in_addr_low; t.wa = in_regs_waddr;
          t.wd = in_regs_wdata; t.pc = in_pc;
          q.push_back(t);
        end
      end
    end
    #1;
  endtask

  task automatic settle(); #1; predict(); endtask

  task automatic idle();
    in_valid = 0; in_req = 0; data_ok = 0; flush = 0;
  endtask

  task automatic set_enq(bit req, logic [1:0] sz, bit sg, logic [2:0] al, logic [31:0] pc);
    in_valid = 1; in_req = req; in_size = sz; in_signed = sg; in_addr_low = al;
    in_regs_we = 1; in_regs_waddr = pc[6:2]; in_regs_wdata = {pc, ~pc}; in_pc = pc;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; out_allowin = 1;
    settle();
    total++; if (in_allowin !== 1'b0) begin bad++; $display("FAIL rst_allowin_high got=%b exp=0", in_allowin); end
    tick(); tick(); rst = 0;
    settle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (in_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b exp=1", in_allowin); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
  endtask

  task automatic test_three_loads();
    logic [63:0] rd;
    out_allowin = 1;
    for (int k = 0; k < 3; k++) begin
      set_enq(1, 2'b10, 0, 3'd0, 32'h200 + 32'(4*k));
      settle();
      total++; if (in_allowin !== 1'b1) begin bad++; $display("FAIL ld3_allow k=%0d got=%b exp=1", k, in_allowin); end
      tick();
    end
    idle(); settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ld3_wait got=%b exp=0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      rd = {$urandom, $urandom};
      data_ok = 1; rdata = rd;
      settle();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ld3_bypass k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_pc !== 32'h200 + 32'(4*k)) begin bad++; $display("FAIL ld3_pc k=%0d got=%h exp=%h", k, out_pc, 32'h200 + 32'(4*k)); end
      total++; if (out_regs_wdata !== {32'd0, rd[31:0]}) begin bad++; $display("FAIL ld3_data k=%0d got=%h exp=%h", k, out_regs_wdata, {32'd0, rd[31:0]}); end
      total++; if (int'(occupancy) !== 3 - k) begin bad++; $display("FAIL ld3_occ k=%0d got=%0d exp=%0d", k, occupancy, 3 - k); end
      tick(); idle(); tick();
    end
    settle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ld3_occ_end got=%0d exp=0", occupancy); end
  endtask

  task automatic issue_load(logic [1:0] sz, bit sg, logic [2:0] al, logic [63:0] rd);
    out_allowin = 1;
    set_enq(1, sz, sg, al, 32'h400);
    tick(); idle();
    data_ok = 1; rdata = rd;
    settle();
  endtask

  task automatic test_extend();
    issue_load(2'b00, 1, 3'd2, 64'h0000_0000_1280_3456);
    total++; if (out_regs_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_s64 got=%h exp=ffffffffffffff80", out_regs_wdata); end
    total++; if (wdata32 !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_s32 got=%h exp=ffffff80", wdata32); end
    tick(); idle();
    issue_load(2'b00, 0, 3'd2, 64'h0000_0000_1280_3456);
    total++; if (out_regs_wdata !== 64'h80) begin bad++; $display("FAIL lb_u64 got=%h exp=80", out_regs_wdata); end
    total++; if (wdata32 !== 32'h80) begin bad++; $display("FAIL lb_u32 got=%h exp=80", wdata32); end
    tick(); idle();
    issue_load(2'b11, 1, 3'd0, 64'h8000_0000_0000_0001);
    total++; if (out_regs_wdata !== 64'h8000_0000_0000_0001) begin bad++; $display("FAIL ld_d64 got=%h exp=8000000000000001", out_regs_wdata); end
    total++; if (wdata32 !== 32'h1) begin bad++; $display("FAIL ld_d32_word got=%h exp=1", wdata32); end
    tick(); idle();
    issue_load(2'b01, 1, 3'd4, 64'h0000_9ABC_0000_0000);
    total++; if (out_regs_wdata !== 64'hFFFF_FFFF_FFFF_9ABC) begin bad++; $display("FAIL lh_s64 got=%h exp=ffffffffffff9abc", out_regs_wdata); end
    tick(); idle(); tick();
  endtask

  task automatic test_full();
    out_allowin = 0;
    for (int k = 0; k < DEPTH; k++) begin
      set_enq(0, 2'b10, 0, 3'd0, 32'h300 + 32'(4*k));
      tick();
    end
    set_enq(0, 2'b10, 0, 3'd0, 32'h310);
    settle();
    total++; if (in_allowin !== 1'b0) begin bad++; $display("FAIL full_block got=%b exp=0", in_allowin); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    out_allowin = 1;
    settle();
    total++; if (in_allowin !== 1'b1) begin bad++; $display("FAIL full_passthru got=%b exp=1", in_allowin); end
    total++; if (out_pc !== 32'h300) begin bad++; $display("FAIL full_head got=%h exp=300", out_pc); end
    tick(); idle(); out_allowin = 0;
    settle();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ_kept got=%0d exp=4", occupancy); end
    total++; if (out_pc !== 32'h304) begin bad++; $display("FAIL full_next got=%h exp=304", out_pc); end
    out_allowin = 1;
    for (int k = 0; k < 5; k++) tick();
    settle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    out_allowin = 1;
    set_enq(1, 2'b10, 0, 3'd0, 32'h500); tick();
    set_enq(1, 2'b10, 0, 3'd0, 32'h504); tick();
    idle(); flush = 1;
    settle();
    total++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b%b exp=00", out_valid, in_allowin); end
    tick(); idle();
    settle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (dut.discard_cnt !== 4'd2) begin bad++; $display("FAIL flush_disc got=%0d exp=2", dut.discard_cnt); end
    set_enq(0, 2'b10, 0, 3'd0, 32'h508); tick(); idle();
    for (int k = 0; k < 2; k++) begin
      data_ok = 1; rdata = 64'hDEAD;
      settle();
      total++; if (out_pc !== 32'h508 || out_regs_wdata !== {32'h508, ~32'h508}) begin bad++; $display("FAIL flush_swallow k=%0d got=%h/%h exp=508", k, out_pc, out_regs_wdata); end
      out_allowin = (k == 1);
      tick(); idle();
    end
    settle();
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL flush_err_early got=%b exp=0", rsp_err); end
    data_ok = 1; tick(); idle();
    settle();
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL flush_err got=%b exp=1", rsp_err); end
    do_reset();
    settle();
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", rsp_err); end
  endtask

  task automatic test_order();
    logic [31:0] seen[$];
    logic [31:0] want[3];
    want[0] = 32'h600; want[1] = 32'h604; want[2] = 32'h608;
    out_allowin = 1;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) set_enq(0, 2'b10, 0, 3'd0, 32'h600);
      if (c == 1) set_enq(1, 2'b10, 0, 3'd0, 32'h604);
      if (c == 2) set_enq(0, 2'b10, 0, 3'd0, 32'h608);
      if (c == 6) begin data_ok = 1; rdata = {$urandom, $urandom}; end
      settle();
      total++; if (out_valid !== e_valid) begin bad++; $display("FAIL ord_valid c=%0d got=%b exp=%b", c, out_valid, e_valid); end
      if (out_valid && out_allowin) seen.push_back(out_pc);
      tick();
    end
    idle();
    total++; if (seen.size() != 3) begin bad++; $display("FAIL ord_count got=%0d exp=3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      total++; if (seen[i] !== want[i]) begin bad++; $display("FAIL ord_pc i=%0d got=%h exp=%h", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_req = 1'($urandom); in_size = 2'($urandom); in_signed = 1'($urandom);
      in_addr_low = 3'($urandom); in_regs_we = 1'($urandom); in_regs_waddr = 5'($urandom);
      in_regs_wdata = {$urandom, $urandom}; in_pc = $urandom; rdata = {$urandom, $urandom};
      out_allowin = ($urandom_range(0, 3) != 0);
      data_ok = ((n_out() + disc) > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 249) == 0);
      settle();
      total++; if (out_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, e_valid); end
      total++; if (in_allowin !== e_allow) begin bad++; $display("FAIL rnd_allow c=%0d got=%b exp=%b", c, in_allowin, e_allow); end
      total++; if (int'(occupancy) !== e_occ) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
      total++; if (rsp_err !== err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, rsp_err, err); end
      if (e_valid) begin
        total++; if (out_regs_wdata !== e_wdata) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_regs_wdata, e_wdata); end
        total++; if (out_pc !== e_pc || out_regs_waddr !== e_wa || out_regs_we !== e_we) begin bad++; $display("FAIL rnd_fields c=%0d got=%h/%h/%b exp=%h/%h/%b", c, out_pc, out_regs_waddr, out_regs_we, e_pc, e_wa, e_we); end
      end
      tick();
      rst = 0;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_three_loads();
    test_extend();
    test_full();
    test_flush();
    test_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
